// File: rtl/serial_deser_arbiter_if.sv
// rtl/serial_deser_arbiter_if.sv - serial requester lanes and tagged parallel word output
interface serial_deser_arbiter_if #(
  parameter int width = 8,
  parameter int n_req = 4,
  parameter int id_w  = $clog2(n_req)
);
  logic [n_req-1:0] req_valid;
  logic [n_req-1:0] req_data;
  logic [n_req-1:0] req_ready;
  logic             parallel_valid;
  logic [width-1:0] parallel_data;
  logic [id_w-1:0]  parallel_id;
  logic             parallel_ready;

  modport master (
    output req_valid, req_data, parallel_ready,
    input  req_ready, parallel_valid, parallel_data, parallel_id
  );

  modport slave (
    input  req_valid, req_data, parallel_ready,
    output req_ready, parallel_valid, parallel_data, parallel_id
  );
endinterface

// File: rtl/serial_deser_arbiter.sv
// rtl/serial_deser_arbiter.sv - round-robin shared serial-to-parallel deserializer
module serial_deser_arbiter #(
  parameter int width = 8,
  parameter int n_req = 4,
  parameter int id_w  = $clog2(n_req)
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_deser_arbiter_if.slave bus
);
  localparam int cnt_w = $clog2(width + 1);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(width - 1);
  localparam logic [id_w-1:0]  last_id  = id_w'(n_req - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [id_w-1:0]  rr_ptr_q, rr_ptr_d;
  logic [id_w-1:0]  grant_q, grant_d;
  logic [cnt_w-1:0] bit_cnt_q, bit_cnt_d;
  logic [width-1:0] shift_q, shift_d;
  logic [width-1:0] pdata_q, pdata_d;
  logic [id_w-1:0]  pid_q, pid_d;
  logic             pvalid_q, pvalid_d;

  logic             found;
  logic [id_w-1:0]  pick;
  int               search_idx;
  logic [width-1:0] shift_in;

  // First valid lane at or after rr_ptr, wrapping past n_req-1 to 0.
  always_comb begin
    found      = 1'b0;
    pick       = rr_ptr_q;
    search_idx = 0;
    for (int k = 0; k < n_req; k++) begin
      search_idx = int'(rr_ptr_q) + k;
      if (search_idx >= n_req) search_idx = search_idx - n_req;
      if (!found && bus.req_valid[search_idx]) begin
        found = 1'b1;
        pick  = id_w'(search_idx);
      end
    end
  end

  assign shift_in = {shift_q[width-2:0], bus.req_data[grant_q]};

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pdata_d   = pdata_q;
    pid_d     = pid_q;
    pvalid_d  = pvalid_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d   = pick;
          bit_cnt_d = '0;
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        // Grant stays locked across gaps; other lanes simply stall.
        if (bus.req_valid[grant_q]) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + cnt_w'(1);
          if (bit_cnt_q == last_cnt) begin
            pdata_d  = shift_in;
            pid_d    = grant_q;
            pvalid_d = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.parallel_ready) begin
          pvalid_d = 1'b0;
          rr_ptr_d = (grant_q == last_id) ? '0 : grant_q + id_w'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      pdata_q   <= '0;
      pid_q     <= '0;
      pvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      pdata_q   <= pdata_d;
      pid_q     <= pid_d;
      pvalid_q  <= pvalid_d;
    end
  end

  // Depends only on state and grant, so parallel_ready never reaches req_ready.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == COLLECT) bus.req_ready[grant_q] = 1'b1;
  end

  assign bus.parallel_valid = pvalid_q;
  assign bus.parallel_data  = pdata_q;
  assign bus.parallel_id    = pid_q;
endmodule

// File: tb/tb_serial_deser_arbiter.sv
// tb/tb_serial_deser_arbiter.sv - directed scoreboard bench for serial_deser_arbiter
module tb_serial_deser_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_deser_arbiter_if #(.width(8), .n_req(4)) bus ();
  serial_deser_arbiter_if #(.width(5), .n_req(4)) bus_b ();

  serial_deser_arbiter #(.width(8), .n_req(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_deser_arbiter #(.width(5), .n_req(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic [9:0]  sb[$];
  int          hs_cyc[$];
  bit          bitq[4][$];
  logic [3:0]  lane_en = 4'hF;
  logic        watch3 = 1'b0;
  int          bad3 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int lane, input logic [7:0] w);
    for (int b = 7; b >= 0; b--) bitq[lane].push_back(w[b]);
  endtask

  task automatic wait_sb(input string tag, input int max_cyc);
    int t = 0;
    while (sb.size() > 0 && t < max_cyc) begin
      @(posedge clk); #1;
      t++;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic wait_pvalid(input string tag, input int max_cyc, output int n);
    logic seen = 1'b0;
    n = 0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      if (bus.parallel_valid === 1'b1) seen = 1'b1;
      else n++;
    end
    check(tag, seen, 1);
  endtask

  // Lane driver: pops a bit after each accepted handshake, presents the next one.
  initial begin
    logic [3:0] acc_snap;
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      acc_snap = bus.req_valid & bus.req_ready;
      @(posedge clk); #2;
      for (int i = 0; i < 4; i++) begin
        if (acc_snap[i] && bitq[i].size() > 0) bitq[i].delete(0);
        bus.req_valid[i] = lane_en[i] && (bitq[i].size() > 0);
        bus.req_data[i]  = (bitq[i].size() > 0) ? bitq[i][0] : 1'b0;
      end
    end
  end

  // Output monitor: every handshake pops the scoreboard.
  initial begin
    logic [9:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.parallel_valid === 1'b1 && bus.parallel_ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_word", {bus.parallel_id, bus.parallel_data}, 32'hFFFF_FFFF);
        end else begin
          exp_w = sb.pop_front();
          check("word_id", bus.parallel_id, exp_w[9:8]);
          check("word_data", bus.parallel_data, exp_w[7:0]);
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (watch3 && bus.req_ready[3]) bad3++;
    end
  end

  initial begin
    int          n;
    int          t;
    int          unstable;
    int          idx;
    int          nw;
    logic        acc;
    logic [7:0]  hold_d;
    logic [1:0]  hold_id;
    logic [9:0]  bits_b;
    logic [4:0]  sbb[$];
    logic [4:0]  exp_b;

    bus.parallel_ready   = 1'b1;
    bus_b.req_valid      = '0;
    bus_b.req_data       = '0;
    bus_b.parallel_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pvalid", bus.parallel_valid, 0);
    check("rst_pdata", bus.parallel_data, 0);
    check("rst_pid", bus.parallel_id, 0);
    check("rst_req_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single requester, back-to-back bits, latency and one-cycle pulse.
    @(posedge clk); #1;
    push_word(2, 8'hB2);
    sb.push_back({2'd2, 8'hB2});
    wait_pvalid("s1_pvalid", 40, n);
    check("s1_latency", n, 9);
    check("s1_ready_in_hold", bus.req_ready, 0);
    @(negedge clk);
    check("s1_pulse", bus.parallel_valid, 0);
    wait_sb("s1_drain", 20);

    // Round robin with every lane busy.
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    hs_cyc.delete();
    push_word(0, 8'h00);
    push_word(0, 8'h00);
    push_word(1, 8'h11);
    push_word(2, 8'h22);
    push_word(3, 8'h33);
    sb.push_back({2'd0, 8'h00});
    sb.push_back({2'd1, 8'h11});
    sb.push_back({2'd2, 8'h22});
    sb.push_back({2'd3, 8'h33});
    sb.push_back({2'd0, 8'h00});
    wait_sb("s2_drain", 120);
    check("s2_words", hs_cyc.size(), 5);
    for (int i = 1; i < hs_cyc.size(); i++) check("s2_period", hs_cyc[i] - hs_cyc[i-1], 10);

    // Gap on lane 1 with lane 3 waiting, then output backpressure.
    bus.parallel_ready = 1'b0;
    bad3 = 0;
    watch3 = 1'b1;
    push_word(1, 8'hA5);
    push_word(3, 8'h3C);
    sb.push_back({2'd1, 8'hA5});
    sb.push_back({2'd3, 8'h3C});
    t = 0;
    while (bitq[1].size() > 4 && t < 40) begin
      @(posedge clk); #3;
      t++;
    end
    lane_en[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("s3_grant_locked", {bus.req_valid[1], bus.req_ready}, {1'b0, 4'b0010});
    repeat (3) @(posedge clk);
    #1;
    lane_en[1] = 1'b1;
    wait_pvalid("s3_pvalid", 60, n);
    watch3 = 1'b0;
    check("s3_lane3_stalled", bad3, 0);
    hold_d   = bus.parallel_data;
    hold_id  = bus.parallel_id;
    unstable = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.parallel_valid !== 1'b1 || bus.parallel_data !== hold_d ||
          bus.parallel_id !== hold_id || bus.req_ready !== 4'b0000) unstable++;
    end
    check("s3_hold_stable", unstable, 0);
    check("s3_hold_word", {hold_id, hold_d}, {2'd1, 8'hA5});
    @(posedge clk); #1;
    bus.parallel_ready = 1'b1;
    wait_sb("s3_drain", 60);

    // Pointer wrap: serve lane 2, then lanes 0 and 3 compete.
    push_word(2, 8'h5A);
    sb.push_back({2'd2, 8'h5A});
    wait_sb("s4_first", 40);
    push_word(0, 8'h96);
    push_word(3, 8'hE7);
    sb.push_back({2'd3, 8'hE7});
    sb.push_back({2'd0, 8'h96});
    wait_sb("s4_drain", 60);

    // Reset in the middle of a word from lane 1.
    push_word(1, 8'hC3);
    t = 0;
    while (bitq[1].size() > 3 && t < 40) begin
      @(posedge clk); #3;
      t++;
    end
    check("s5_mid_word", bus.req_ready, 4'b0010);
    rst = 1'b0;
    #1;
    check("s5_ready_cleared", bus.req_ready, 0);
    check("s5_valid_cleared", bus.parallel_valid, 0);
    for (int i = 0; i < 4; i++) bitq[i].delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    push_word(1, 8'h69);
    sb.push_back({2'd1, 8'h69});
    wait_sb("s5_fresh", 40);

    // Width 5 instance: two back-to-back words from lane 0.
    bits_b = 10'b11001_10110;
    sbb.push_back(5'b11001);
    sbb.push_back(5'b10110);
    idx = 0;
    nw  = 0;
    @(posedge clk); #1;
    bus_b.req_data  = {3'b000, bits_b[9]};
    bus_b.req_valid = 4'b0001;
    for (int k = 0; k < 80 && sbb.size() > 0; k++) begin
      @(negedge clk);
      acc = bus_b.req_valid[0] & bus_b.req_ready[0];
      if (bus_b.parallel_valid === 1'b1) begin
        exp_b = sbb.pop_front();
        check("b_accepts", idx, 5 * (nw + 1));
        check("b_id", bus_b.parallel_id, 0);
        check("b_data", bus_b.parallel_data, exp_b);
        nw++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      if (idx < 10) bus_b.req_data[0] = bits_b[9 - idx];
      else bus_b.req_valid = '0;
    end
    check("b_drain", sbb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_deser_arbiter.md
Name: serial_deser_arbiter

Overview:
Shares one width-bit serial-to-parallel deserializer between n_req serial requesters. A round-robin arbiter grants one requester at a time and holds the grant for one complete word of width accepted bits. The block then presents the assembled word, tagged with the source index, on a valid/ready parallel output. It sits between the per-lane serial front ends and the word-level consumer.

Parameters:
width, 8, bits per assembled word (>= 2)
n_req, 4, number of serial requesters (>= 2)
id_w, $clog2(n_req), width of source index output

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset; clears all state immediately when low
req_valid  input  n_req  per-requester: serial bit on req_data[i] is valid
req_data  input  n_req  per-requester serial data bit
req_ready  output  n_req  one-hot or zero; bit i accepted when req_valid[i] && req_ready[i]
parallel_valid  output  1  assembled word available
parallel_data  output  width  assembled word, first accepted bit at MSB
parallel_id  output  id_w  index of requester that produced parallel_data
parallel_ready  input  1  consumer accepts word when parallel_valid && parallel_ready

Behaviour:
- Reset (rst low, async): state=IDLE, rr_ptr=0, grant=0, bit_cnt=0, shift=0; parallel_valid=0, parallel_data=0, parallel_id=0, req_ready=0. Reset mid-word discards the partial word; no output produced.
- States: IDLE, COLLECT, HOLD.
- IDLE: req_ready=0. If any req_valid, select the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... wrapping modulo n_req. Register grant=i, bit_cnt=0, go to COLLECT. With no requests, stay in IDLE.
- COLLECT: req_ready[grant]=1 (combinational from state/grant), all other bits 0.
  - On accept: shift <= {shift[width-2:0], req_data[grant]}; bit_cnt++.
  - Gaps (req_valid[grant]=0) are allowed; the grant stays locked and no bit is taken.
  - Other requesters' valids are ignored; they are never dropped, only stalled.
  - On the accept that makes bit_cnt reach width: load parallel_data with the full word including this bit, parallel_id=grant, parallel_valid=1 (registered, visible next cycle), go to HOLD.
  - bit_cnt is sized $clog2(width+1). Must be correct for non-power-of-2 width; no fixed 3-bit counter.
- HOLD: req_ready=0.
  - parallel_data and parallel_id are stable while parallel_valid=1 && !parallel_ready.
  - On handshake: parallel_valid=0, rr_ptr=(grant+1) mod n_req, go to IDLE.
- Latency: last bit accepted at cycle T -> parallel_valid=1 at T+1. Minimum word period is width+2 cycles (1 IDLE + width COLLECT + 1 HOLD with parallel_ready held high).
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,n_req-1,0. No requester waits more than n_req-1 words.
- Wrap-around: rr_ptr=n_req-1 followed by a handshake sets rr_ptr=0. The search wraps past n_req-1 to 0.
- No combinational path from parallel_ready to req_ready.

Test Plan:
- Reset then single requester: width=8, n_req=4; req 2 sends bits 1,0,1,1,0,0,1,0 back-to-back with parallel_ready=1 -> parallel_valid pulses 1 cycle, 1 cycle after the 8th bit; parallel_data=8'hB2, parallel_id=2.
- Round-robin: all 4 requesters continuously valid, each sending its index pattern (8'h00, 8'h11, 8'h22, 8'h33) -> output ids 0,1,2,3,0 in order; data matches id; 10 cycles per word.
- Gaps and backpressure: req 1 drops valid for 3 cycles mid-word while req 3 is valid; parallel_ready=0 for 5 cycles -> req 3 never gets req_ready during req 1's word; word=8'hA5 completes; output held stable 5 cycles, accepted on cycle 6; the next grant goes to 3.
- Wrap-around: rr_ptr=3 after serving req 2, only req 0 and req 3 valid -> req 3 is granted, then req 0 next.
- Reset mid-operation: rst low after 5 of 8 bits from req 1 -> req_ready and parallel_valid go to 0 immediately, no word emitted. After release, a fresh 8-bit word from req 1 yields exactly that word and id=1.
- Non-power-of-2 width: width=5, bits 1,1,0,0,1 from req 0 -> parallel_data=5'b11001, exactly 5 accepts per word.
